// File: rtl/sys_array.sv
// rtl/sys_array.sv - weight-stationary systolic MAC array of rows_num x rows_num PEs
// Weights shift down columns, operands and act flags move right, partial sums move down.
module sys_array #(
    parameter int rows_num = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    active,
    input  logic [8*rows_num-1:0]   data_in,
    input  logic [8*rows_num-1:0]   w_in,
    input  logic [16*rows_num-1:0]  sum_in,
    input  logic [rows_num-1:0]     weight_wren,
    output logic [16*rows_num-1:0]  mac_out,
    output logic [8*rows_num-1:0]   w_out,
    output logic [rows_num-1:0]     weight_wren_out,
    output logic [rows_num-1:0]     active_out,
    output logic [8*rows_num-1:0]   data_out
);

    logic [7:0]  weight_q [rows_num][rows_num];
    logic [7:0]  weight_d [rows_num][rows_num];
    logic [7:0]  data_q   [rows_num][rows_num];
    logic [7:0]  data_d   [rows_num][rows_num];
    logic        act_q    [rows_num][rows_num];
    logic        act_d    [rows_num][rows_num];
    logic [15:0] sum_q    [rows_num][rows_num];
    logic [15:0] sum_d    [rows_num][rows_num];
    logic [rows_num-1:0] weight_wren_out_q;
    logic [rows_num-1:0] weight_wren_out_d;

    always_comb begin
        weight_wren_out_d = weight_wren;
    end

    for (genvar r = 0; r < rows_num; r++) begin : g_row
        for (genvar c = 0; c < rows_num; c++) begin : g_col
            logic [7:0]  in_data;
            logic        in_act;
            logic [7:0]  w_src;
            logic [15:0] sin;
            logic [15:0] prod;

            // act registers hold the PE's incoming act, so column 0 chains down the rows
            if (c == 0) begin : g_left
                assign in_data = data_in[8*r +: 8];
                if (r == 0) begin : g_top
                    assign in_act = active;
                end else begin : g_below
                    assign in_act = act_q[r-1][0];
                end
            end else begin : g_inner
                assign in_data = data_q[r][c-1];
                assign in_act  = act_q[r][c-1];
            end

            if (r == 0) begin : g_first
                assign w_src = w_in[8*c +: 8];
                assign sin   = sum_in[16*c +: 16];
            end else begin : g_rest
                assign w_src = weight_q[r-1][c];
                assign sin   = sum_q[r-1][c];
            end

            // product uses the pre-edge weight even while the column is shifting
            assign prod             = 16'(in_data) * 16'(weight_q[r][c]);
            assign weight_d[r][c]   = weight_wren[c] ? w_src : weight_q[r][c];
            assign data_d[r][c]     = in_data;
            assign act_d[r][c]      = in_act;
            assign sum_d[r][c]      = in_act ? (sin + prod) : sin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < rows_num; r++) begin
                for (int c = 0; c < rows_num; c++) begin
                    weight_q[r][c] <= '0;
                    data_q[r][c]   <= '0;
                    act_q[r][c]    <= 1'b0;
                    sum_q[r][c]    <= '0;
                end
            end
            weight_wren_out_q <= '0;
        end else begin
            for (int r = 0; r < rows_num; r++) begin
                for (int c = 0; c < rows_num; c++) begin
                    weight_q[r][c] <= weight_d[r][c];
                    data_q[r][c]   <= data_d[r][c];
                    act_q[r][c]    <= act_d[r][c];
                    sum_q[r][c]    <= sum_d[r][c];
                end
            end
            weight_wren_out_q <= weight_wren_out_d;
        end
    end

    for (genvar i = 0; i < rows_num; i++) begin : g_out
        assign mac_out[16*i +: 16] = sum_q[rows_num-1][i];
        assign w_out[8*i +: 8]     = weight_q[rows_num-1][i];
        assign data_out[8*i +: 8]  = data_q[i][rows_num-1];
        assign active_out[i]       = act_q[i][rows_num-1];
    end

    assign weight_wren_out = weight_wren_out_q;

endmodule

// File: tb/tb_sys_array.sv
// tb/tb_sys_array.sv - scoreboard bench for sys_array (rows_num = 4)
module tb_sys_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        active;
    logic [31:0] data_in;
    logic [31:0] w_in;
    logic [63:0] sum_in;
    logic [3:0]  weight_wren;
    logic [63:0] mac_out;
    logic [31:0] w_out;
    logic [3:0]  weight_wren_out;
    logic [3:0]  active_out;
    logic [31:0] data_out;

    sys_array #(.rows_num(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .active          (active),
        .data_in         (data_in),
        .w_in            (w_in),
        .sum_in          (sum_in),
        .weight_wren     (weight_wren),
        .mac_out         (mac_out),
        .w_out           (w_out),
        .weight_wren_out (weight_wren_out),
        .active_out      (active_out),
        .data_out        (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push(input int dly, input int kind, input int idx, input logic [31:0] val);
        exp_t e;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic check_due();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    0: check($sformatf("mac_out[%0d]@%0d", sb[i].idx, cyc),
                             {16'h0, mac_out[16*sb[i].idx +: 16]}, sb[i].val);
                    1: check($sformatf("data_out@%0d", cyc), data_out, sb[i].val);
                    default: check($sformatf("active_out@%0d", cyc), {28'h0, active_out}, sb[i].val);
                endcase
                sb.delete(i);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mac_out_lo"}, mac_out[31:0], 32'h0);
        check({tag, "_mac_out_hi"}, mac_out[63:32], 32'h0);
        check({tag, "_w_out"}, w_out, 32'h0);
        check({tag, "_wren_out"}, {28'h0, weight_wren_out}, 32'h0);
        check({tag, "_active_out"}, {28'h0, active_out}, 32'h0);
        check({tag, "_data_out"}, data_out, 32'h0);
    endtask

    // words[0] goes in first and must end up in the bottom row
    task automatic load_weights(input logic [127:0] words);
        weight_wren = 4'hF;
        for (int k = 0; k < 4; k++) begin
            w_in = words[32*k +: 32];
            step();
            if (k == 0) check("wren_out_high", {28'h0, weight_wren_out}, 32'hF);
        end
        check("w_out_loaded", w_out, words[31:0]);
        weight_wren = 4'h0;
        w_in        = 32'hDEADBEEF;
        step();
        check("wren_out_low", {28'h0, weight_wren_out}, 32'h0);
        idle(2);
        check("w_out_hold", w_out, words[31:0]);
    endtask

    task automatic mac_vec(input logic [31:0] vec, input logic [63:0] exp);
        for (int c = 0; c < 4; c++) push(4 + c, 0, c, {16'h0, exp[16*c +: 16]});
        for (int k = 0; k < 4; k++) begin
            active  = 1'b1;
            data_in = 32'h0;
            data_in[8*k +: 8] = vec[8*k +: 8];
            step();
        end
        active  = 1'b0;
        data_in = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; active = 1'b0; data_in = 32'h0; w_in = 32'h0;
        sum_in = 64'h0; weight_wren = 4'h0;
        #1;
        check_all_zero("reset0");
        #11;
        rst_n = 1'b1;

        load_weights({4{32'h04030201}});
        push(4, 2, 0, 32'h1);
        push(7, 2, 0, 32'hF);
        mac_vec(32'h04030201, {16'd40, 16'd30, 16'd20, 16'd10});
        idle(12);

        load_weights({32'hD0D1D2D3, 32'hC0C1C2C3, 32'hB0B1B2B3, 32'hA0A1A2A3});

        load_weights({4{32'hFFFFFFFF}});
        mac_vec(32'hFFFFFFFF, {4{16'hF804}});
        idle(12);

        sum_in = {4{16'h1234}};
        for (int c = 0; c < 4; c++) push(4, 0, c, 32'h1234);
        for (int k = 0; k < 8; k++) begin
            data_in = $urandom;
            push(4, 1, 0, data_in);
            step();
        end
        data_in = 32'h0;
        idle(6);
        sum_in = 64'h0;

        weight_wren = 4'hF;
        w_in        = 32'hFFFFFFFF;
        active      = 1'b1;
        data_in     = 32'h00000009;
        step();
        data_in     = 32'h00000900;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        sb.delete();
        weight_wren = 4'h0;
        active      = 1'b0;
        data_in     = 32'h0;
        #3;
        rst_n = 1'b1;
        idle(10);
        check("w_out_after_reset", w_out, 32'h0);
        sum_in = {4{16'h0005}};
        mac_vec(32'h07070707, {4{16'h0005}});
        idle(12);

        check("scoreboard_drained", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sys_array.md
SYS_ARRAY -- requirements
Module: sys_array

Interface
REQ-001 SHALL have parameter rows_num, default 4, giving the array dimension (rows_num x rows_num PEs); legal range 1..16.
REQ-002 SHALL have port clk, input, 1 bit; the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-004 SHALL have port active, input, 1 bit; compute-enable entering row 0 at the left edge.
REQ-005 SHALL have port data_in, input, 8*rows_num bits; byte r (bits 8r+7:8r) is the unsigned operand entering row r at the left edge.
REQ-006 SHALL have port w_in, input, 8*rows_num bits; byte c is the unsigned weight entering column c at the top edge.
REQ-007 SHALL have port sum_in, input, 16*rows_num bits; halfword c is the partial sum entering column c at the top.
REQ-008 SHALL have port weight_wren, input, rows_num bits; bit c enables the weight shift in column c.
REQ-009 SHALL have port mac_out, output, 16*rows_num bits; halfword c is the sum leaving the bottom of column c.
REQ-010 SHALL have port w_out, output, 8*rows_num bits; byte c is the weight held in the bottom-row PE of column c.
REQ-011 SHALL have port weight_wren_out, output, rows_num bits; weight_wren delayed one cycle.
REQ-012 SHALL have port active_out, output, rows_num bits; bit r is the active flag leaving the right edge of row r.
REQ-013 SHALL have port data_out, output, 8*rows_num bits; byte r is the operand leaving the right edge of row r.

Function
REQ-014 SHALL contain a grid of PEs, PE(r,c) with r = row (0 top) and c = column (0 left); each PE holds registers weight[7:0], data[7:0], act and sum[15:0].
REQ-015 SHALL, on each edge where weight_wren[c]=1, load PE(0,c).weight from w_in byte c and each PE(r,c).weight (r>0) from PE(r-1,c).weight; weights SHALL hold while weight_wren[c]=0.
REQ-016 SHALL therefore place the first of rows_num consecutive written words in row rows_num-1 and the last in row 0.
REQ-017 SHALL register data every cycle: PE(r,0).data from data_in byte r; PE(r,c).data (c>0) from PE(r,c-1).data.
REQ-018 SHALL delay active by one register per row down column 0 (PE(0,0).act from active; PE(r,0).act from PE(r-1,0).act) and by one register per PE rightward along each row.
REQ-019 SHALL compute each PE's sum input (sin) as sum_in halfword c for row 0 and PE(r-1,c).sum otherwise.
REQ-020 SHALL, on each edge, set PE(r,c).sum to sin + incoming_data*PE(r,c).weight when the PE's incoming act is 1, and to sin otherwise.
REQ-021 SHALL take the incoming data and act of a PE from the left-neighbour registers, or from the primary inputs/column-0 chain for c=0.
REQ-022 SHALL use an unsigned 8x8 -> 16-bit product and a modulo 2^16 (wrap-around) add; no saturation and no overflow flag.
REQ-023 SHALL drive mac_out[c] = PE(rows_num-1,c).sum, data_out[r] = PE(r,rows_num-1).data, active_out[r] = PE(r,rows_num-1).act and w_out[c] = PE(rows_num-1,c).weight, all registered.
REQ-024 SHALL, when weight_wren and active are high on the same edge, compute the MAC with the pre-edge weight.
REQ-025 SHALL have a latency for a row-skewed input vector (row r presented r cycles after row 0, active high over the same window) such that column c's result appears on mac_out rows_num+c edges after row 0 is presented.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear all weight, data, act and sum registers and weight_wren_out to zero, so every output reads 0.
REQ-027 SHALL make reset asserted mid-load or mid-compute discard all loaded weights and partial sums; operation SHALL resume from the all-zero state on the first edge after release.

Verification
REQ-028 SHALL pass this check: with rows_num=4 and reset, all outputs = 0 immediately, without waiting for a clock edge.
REQ-029 SHALL pass this check: w_in=0x04030201 with weight_wren=4'b1111 for 4 edges, then wren=0 -> every PE in column c holds c+1, w_out=0x04030201 and weight_wren_out follows weight_wren one cycle late.
REQ-030 SHALL pass this check: with the REQ-029 weights, sum_in=0 and skewed vector (1,2,3,4) with active -> mac_out columns 0..3 = 10,20,30,40, column c appearing 4+c edges after row 0.
REQ-031 SHALL pass this check: all weights 0xFF and all data 0xFF, with a skewed vector, -> each column = 4*0xFE01 mod 2^16 = 0xF804 (wrap).
REQ-032 SHALL pass this check: active=0 with sum_in halfword c = 0x1234 -> mac_out[c] = 0x1234 after 4 edges, and data_out equals data_in delayed 4 cycles.
REQ-033 SHALL pass this check: rst_n pulsed low mid-compute -> outputs go to 0 at once and subsequent results reflect zero weights.
